matmul_apb_monitor: RTL and testbench

- Synthesizable, parametrised APB protocol and matmul-slave rule monitor.
- Passively taps the APB bus between the host and the matmul slave, together with the slave's busy signal.
- Tracks APB phases with a state machine and checks six rules: timeout, busy-error response, address range, start-to-busy latency, signal stability and phase ordering.
- Records sticky per-rule flags, a saturating error count and a first-error capture, readable by firmware or the testbench. It never drives the bus.

---
 rtl/matmul_apb_monitor.sv | 171 +++++++++++++++++
 tb/tb_matmul_apb_monitor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/matmul_apb_monitor.sv
// Passive APB / matmul-slave rule monitor: tracks APB phases, checks six bus rules
// and records sticky flags, a saturating violation count and a first-error capture.
module matmul_apb_monitor #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_MAX   = 320,
    parameter int unsigned TIMEOUT    = 16,
    parameter int unsigned START_LAT  = 2,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic                  busy,
    input  logic                  clr,
    output logic [5:0]            err_flags,
    output logic                  err_pulse,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [2:0]            first_err_id,
    output logic [ADDR_WIDTH-1:0] first_err_addr
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(START_LAT + 2);
    localparam logic [ADDR_WIDTH-1:0] AddrMax    = ADDR_WIDTH'(ADDR_MAX);
    localparam logic [TW-1:0]         TimeoutVal = TW'(TIMEOUT);
    localparam logic [SW-1:0]         StartFire  = SW'(START_LAT + 1);

    // StSetup: previous cycle was the APB setup phase, so this cycle must be the first ACCESS.
    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e                  st_q, st_d;
    logic [TW-1:0]           acc_q, acc_d;
    logic                    arm_q, arm_d;
    logic [SW-1:0]           scnt_q, scnt_d;
    logic [ADDR_WIDTH-1:0]   lat_addr_q, lat_addr_d;
    logic                    lat_write_q, lat_write_d;
    logic [DATA_WIDTH-1:0]   lat_data_q, lat_data_d;
    logic [5:0]              fired;
    logic                    in_acc, acc_phase, complete, start_go;

    always_comb begin
        st_d        = st_q;
        acc_d       = acc_q;
        arm_d       = arm_q;
        scnt_d      = scnt_q;
        lat_addr_d  = lat_addr_q;
        lat_write_d = lat_write_q;
        lat_data_d  = lat_data_q;
        fired       = '0;
        in_acc      = (st_q == StSetup) || (st_q == StAccess);
        acc_phase   = in_acc && psel && penable;
        complete    = acc_phase && pready;
        start_go    = complete && pwrite && (paddr == '0) && pwdata[0] && !busy;

        unique case (st_q)
            StIdle: begin
                if (psel && !penable) begin
                    st_d        = StSetup;
                    lat_addr_d  = paddr;
                    lat_write_d = pwrite;
                    lat_data_d  = pwdata;
                end
            end
            StSetup, StAccess: begin
                if (psel && penable) begin
                    if (pready) begin
                        st_d  = StIdle;
                        acc_d = '0;
                    end else if (acc_q + TW'(1) == TimeoutVal) begin
                        fired[0] = 1'b1;
                        st_d     = StIdle;
                        acc_d    = '0;
                    end else begin
                        st_d  = StAccess;
                        acc_d = acc_q + TW'(1);
                    end
                end else begin
                    fired[5] = 1'b1;
                    st_d     = StIdle;
                    acc_d    = '0;
                end
            end
            default: st_d = StIdle;
        endcase

        if (penable && !psel) fired[5] = 1'b1;
        if ((st_q == StSetup) && (paddr > AddrMax)) fired[2] = 1'b1;
        if (complete && busy && !pslverr) fired[1] = 1'b1;
        if (acc_phase && ((paddr != lat_addr_q) || (pwrite != lat_write_q) ||
                          (lat_write_q && (pwdata != lat_data_q)))) begin
            fired[4] = 1'b1;
        end

        // A fresh start while armed restarts the latency window instead of firing.
        if (start_go) begin
            arm_d  = 1'b1;
            scnt_d = '0;
        end else if (arm_q) begin
            if (busy) begin
                arm_d  = 1'b0;
                scnt_d = '0;
            end else if (scnt_q + SW'(1) == StartFire) begin
                fired[3] = 1'b1;
                arm_d    = 1'b0;
                scnt_d   = '0;
            end else begin
                scnt_d = scnt_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q        <= StIdle;
            acc_q       <= '0;
            arm_q       <= 1'b0;
            scnt_q      <= '0;
            lat_addr_q  <= '0;
            lat_write_q <= 1'b0;
            lat_data_q  <= '0;
        end else begin
            st_q        <= st_d;
            acc_q       <= acc_d;
            arm_q       <= arm_d;
            scnt_q      <= scnt_d;
            lat_addr_q  <= lat_addr_d;
            lat_write_q <= lat_write_d;
            lat_data_q  <= lat_data_d;
        end
    end

    logic [2:0] low_id;
    always_comb begin
        low_id = 3'd7;
        for (int i = 5; i >= 0; i--) begin
            if (fired[i]) low_id = 3'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flags      <= '0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
            first_err_id   <= 3'd7;
            first_err_addr <= '0;
        end else if (clr) begin
            err_flags      <= '0;
            err_pulse      <= 1'b0;
            err_count      <= '0;
            first_err_id   <= 3'd7;
            first_err_addr <= '0;
        end else begin
            err_pulse <= |fired;
            err_flags <= err_flags | fired;
            if ((|fired) && (err_count != '1)) err_count <= err_count + CNT_WIDTH'(1);
            if ((|fired) && (first_err_id == 3'd7)) begin
                first_err_id   <= low_id;
                first_err_addr <= paddr;
            end
        end
    end

endmodule

// File: tb/tb_matmul_apb_monitor.sv
// Directed self-checking bench for matmul_apb_monitor with default parameters.
module tb_matmul_apb_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic        pready = 1'b0, pslverr = 1'b0, busy = 1'b0, clr = 1'b0;
    logic [5:0]  err_flags;
    logic        err_pulse;
    logic [7:0]  err_count;
    logic [2:0]  first_err_id;
    logic [31:0] first_err_addr;

    int n_checks = 0;
    int n_fail   = 0;

    matmul_apb_monitor #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .ADDR_MAX(320),
        .TIMEOUT(16), .START_LAT(2), .CNT_WIDTH(8)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pready(pready), .pslverr(pslverr),
        .busy(busy), .clr(clr), .err_flags(err_flags), .err_pulse(err_pulse),
        .err_count(err_count), .first_err_id(first_err_id), .first_err_addr(first_err_addr)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_idle();
        psel = 0; penable = 0; pready = 0; pslverr = 0;
    endtask

    task automatic setup_phase(input logic [31:0] a, input logic w, input logic [31:0] d);
        psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d; pready = 0;
        tick(1);
    endtask

    task automatic do_clr();
        bus_idle(); clr = 1; tick(1); clr = 0;
    endtask

    task automatic test_reset();
        tick(2);
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL reset_flags got %0h exp 0", err_flags); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_pulse got %0b exp 0", err_pulse); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", err_count); end
        n_checks++; if (first_err_id !== 3'd7) begin n_fail++; $display("FAIL reset_id got %0d exp 7", first_err_id); end
        n_checks++; if (first_err_addr !== 32'd0) begin n_fail++; $display("FAIL reset_addr got %0h exp 0", first_err_addr); end
        rst = 0;
        tick(1);
    endtask

    task automatic test_legal_write();
        setup_phase(32'd8, 1'b1, 32'h5);
        penable = 1; pready = 1; tick(1);
        bus_idle(); tick(2);
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL legal_flags got %0h exp 0", err_flags); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL legal_count got %0d exp 0", err_count); end
        n_checks++; if (first_err_id !== 3'd7) begin n_fail++; $display("FAIL legal_id got %0d exp 7", first_err_id); end
    endtask

    task automatic test_timeout();
        setup_phase(32'h40, 1'b0, 32'h0);
        penable = 1; pready = 0;
        tick(15);
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL tmo_early got %0h exp 0", err_flags); end
        tick(1);
        n_checks++; if (err_flags !== 6'b000001) begin n_fail++; $display("FAIL tmo_flags got %0h exp 1", err_flags); end
        n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL tmo_pulse_on got %0b exp 1", err_pulse); end
        tick(1);
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_off got %0b exp 0", err_pulse); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL tmo_count got %0d exp 1", err_count); end
        n_checks++; if (first_err_id !== 3'd0) begin n_fail++; $display("FAIL tmo_id got %0d exp 0", first_err_id); end
        n_checks++; if (first_err_addr !== 32'h40) begin n_fail++; $display("FAIL tmo_addr got %0h exp 40", first_err_addr); end
        bus_idle(); tick(1);
        do_clr();
    endtask

    task automatic test_start();
        busy = 0;
        setup_phase(32'd0, 1'b1, 32'h1);
        penable = 1; pready = 1; tick(1);
        bus_idle(); tick(1);
        busy = 1; tick(1);
        tick(3);
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL start_ok got %0h exp 0", err_flags); end
        busy = 0; tick(1);
        setup_phase(32'd0, 1'b1, 32'h1);
        penable = 1; pready = 1; tick(1);
        bus_idle(); tick(2);
        n_checks++; if (err_flags[3] !== 1'b0) begin n_fail++; $display("FAIL start_early got %0b exp 0", err_flags[3]); end
        tick(1);
        n_checks++; if (err_flags !== 6'b001000) begin n_fail++; $display("FAIL start_flags got %0h exp 8", err_flags); end
        n_checks++; if (err_pulse !== 1'b1) begin n_fail++; $display("FAIL start_pulse got %0b exp 1", err_pulse); end
        n_checks++; if (first_err_id !== 3'd3) begin n_fail++; $display("FAIL start_id got %0d exp 3", first_err_id); end
        do_clr();
    endtask

    task automatic test_busy_addr();
        setup_phase(32'd400, 1'b0, 32'h0);
        penable = 1; pready = 1; busy = 1; pslverr = 0; tick(1);
        bus_idle(); busy = 0;
        n_checks++; if (err_flags !== 6'b000110) begin n_fail++; $display("FAIL ba_flags got %0h exp 6", err_flags); end
        n_checks++; if (err_count !== 8'd1) begin n_fail++; $display("FAIL ba_count got %0d exp 1", err_count); end
        n_checks++; if (first_err_id !== 3'd1) begin n_fail++; $display("FAIL ba_id got %0d exp 1", first_err_id); end
        n_checks++; if (first_err_addr !== 32'd400) begin n_fail++; $display("FAIL ba_addr got %0d exp 400", first_err_addr); end
        tick(1);
        do_clr();
    endtask

    task automatic test_stable_proto_clr();
        setup_phase(32'd16, 1'b1, 32'hAB);
        penable = 1; pready = 1; paddr = 32'd20; tick(1);
        psel = 0; penable = 1; pready = 0; tick(1);
        bus_idle(); tick(1);
        n_checks++; if (err_flags !== 6'b110000) begin n_fail++; $display("FAIL sp_flags got %0h exp 30", err_flags); end
        n_checks++; if (err_count !== 8'd2) begin n_fail++; $display("FAIL sp_count got %0d exp 2", err_count); end
        n_checks++; if (first_err_id !== 3'd4) begin n_fail++; $display("FAIL sp_id got %0d exp 4", first_err_id); end
        n_checks++; if (first_err_addr !== 32'd20) begin n_fail++; $display("FAIL sp_addr got %0d exp 20", first_err_addr); end
        // clr wins over a violation sampled on the same edge
        psel = 0; penable = 1; clr = 1; tick(1);
        clr = 0; bus_idle();
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL clr_flags got %0h exp 0", err_flags); end
        n_checks++; if (err_pulse !== 1'b0) begin n_fail++; $display("FAIL clr_pulse got %0b exp 0", err_pulse); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL clr_count got %0d exp 0", err_count); end
        n_checks++; if (first_err_id !== 3'd7) begin n_fail++; $display("FAIL clr_id got %0d exp 7", first_err_id); end
        n_checks++; if (first_err_addr !== 32'd0) begin n_fail++; $display("FAIL clr_addr got %0h exp 0", first_err_addr); end
        tick(1);
    endtask

    task automatic test_saturate();
        psel = 0; penable = 1;
        tick(254);
        n_checks++; if (err_count !== 8'd254) begin n_fail++; $display("FAIL sat_mid got %0d exp 254", err_count); end
        tick(46);
        penable = 0; tick(1);
        n_checks++; if (err_count !== 8'd255) begin n_fail++; $display("FAIL sat_count got %0d exp 255", err_count); end
        n_checks++; if (err_flags !== 6'b100000) begin n_fail++; $display("FAIL sat_flags got %0h exp 20", err_flags); end
        n_checks++; if (first_err_id !== 3'd5) begin n_fail++; $display("FAIL sat_id got %0d exp 5", first_err_id); end
    endtask

    task automatic test_reset_mid_access();
        setup_phase(32'd8, 1'b0, 32'h0);
        penable = 1; pready = 0; tick(2);
        #2 rst = 1;
        #1;
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_count got %0d exp 0", err_count); end
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL rst_flags got %0h exp 0", err_flags); end
        n_checks++; if (first_err_id !== 3'd7) begin n_fail++; $display("FAIL rst_id got %0d exp 7", first_err_id); end
        tick(1);
        bus_idle(); rst = 0;
        // A monitor stuck in ACCESS would flag the dropped psel as a protocol error.
        tick(3);
        n_checks++; if (err_flags !== 6'd0) begin n_fail++; $display("FAIL rst_fsm_flags got %0h exp 0", err_flags); end
        n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL rst_fsm_count got %0d exp 0", err_count); end
    endtask

    initial begin
        test_reset();
        test_legal_write();
        test_timeout();
        test_start();
        test_busy_addr();
        test_stable_proto_clr();
        test_saturate();
        test_reset_mid_access();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
